// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extend/shift unit: state encoding and
// an elaboration-time parameter sanity check.
package imm_ext_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_e;

    // True when the output is wide enough for the immediate and the fixed
    // jump shift fits the shift counter.
    function automatic bit widths_ok(input int in_w, input int out_w,
                                     input int shamt_w, input int jump_shift);
        return (out_w >= in_w) && (jump_shift >= 0) &&
               (jump_shift < (1 << shamt_w));
    endfunction

endpackage

// File: rtl/imm_extender.sv
// Combinational sign/zero extension of an IN_WIDTH immediate to OUT_WIDTH.
// Shared with decode for immediates that need no shift.
module imm_extender #(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 zext,
    output logic [OUT_WIDTH-1:0] ext
);

    generate
        if (OUT_WIDTH == IN_WIDTH) begin : g_identity
            assign ext = data_in;
        end else begin : g_extend
            // Pad bit is the immediate's sign unless zero extension is requested.
            logic w_pad;
            assign w_pad = zext ? 1'b0 : data_in[IN_WIDTH-1];
            assign ext   = {{(OUT_WIDTH-IN_WIDTH){w_pad}}, data_in};
        end
    endgenerate

endmodule

// File: rtl/imm_extend_shift_unit.sv
// Registered immediate generator: extends an immediate, then left-shifts it
// one bit per cycle by a runtime or fixed jump amount, flagging lost bits.
module imm_extend_shift_unit
    import imm_ext_pkg::*;
#(
    parameter int IN_WIDTH   = 12,
    parameter int OUT_WIDTH  = 16,
    parameter int SHAMT_W    = 3,
    parameter int JUMP_SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 zext,
    input  logic                 jump,
    input  logic [SHAMT_W-1:0]   shamt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 ovf,
    output logic                 busy
);

    generate
        if (!widths_ok(IN_WIDTH, OUT_WIDTH, SHAMT_W, JUMP_SHIFT)) begin : g_bad_params
            $error("imm_extend_shift_unit: need OUT_WIDTH >= IN_WIDTH and JUMP_SHIFT < 2**SHAMT_W");
        end
    endgenerate

    localparam logic [SHAMT_W-1:0] JUMP_N = SHAMT_W'(JUMP_SHIFT);
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_e               r_state;
    logic [OUT_WIDTH-1:0] r_shreg;
    logic [SHAMT_W-1:0]   r_cnt;
    logic                 r_s0;
    logic                 r_ovf_acc;
    logic                 r_zext;

    logic [OUT_WIDTH-1:0] w_ext;
    logic [SHAMT_W-1:0]   w_n;
    logic                 w_accept;
    logic                 w_msb;
    logic                 w_lost;

    imm_extender #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_extender (
        .data_in (data_in),
        .zext    (zext),
        .ext     (w_ext)
    );

    assign w_n      = jump ? JUMP_N : shamt;
    assign w_accept = in_valid & in_ready;
    assign w_msb    = r_shreg[OUT_WIDTH-1];
    // A departing bit is significant if it is a 1 (unsigned) or differs from the sign.
    assign w_lost   = r_zext ? w_msb : (w_msb != r_s0);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would chain shreg/counter updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_s0      <= 1'b0;
            r_ovf_acc <= 1'b0;
            r_zext    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shreg   <= w_ext;
                        r_cnt     <= w_n;
                        r_s0      <= w_ext[OUT_WIDTH-1];
                        r_ovf_acc <= 1'b0;
                        r_zext    <= zext;
                        r_state   <= (w_n == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt - CNT_ONE;
                    if (w_lost) begin
                        r_ovf_acc <= 1'b1;
                    end
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are forced to their reset values while rst is held.
    assign in_ready  = !rst && (r_state == S_IDLE);
    assign out_valid = !rst && (r_state == S_DONE);
    assign busy      = !rst && (r_state != S_IDLE);
    assign data_out  = out_valid ? r_shreg : '0;
    assign ovf       = out_valid && (r_ovf_acc || (!r_zext && (w_msb != r_s0)));

endmodule

// File: tb/tb_imm_extend_shift_unit.sv
// Directed self-checking bench for imm_extend_shift_unit at default parameters.
module tb_imm_extend_shift_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] data_in = '0;
    logic        zext = 1'b0;
    logic        jump = 1'b0;
    logic [2:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] data_out;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int failures = 0;

    imm_extend_shift_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .zext      (zext),
        .jump      (jump),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Issue one request, wait for out_valid (bounded), capture, then consume it.
    // Latency 1 means out_valid is already high right after the accept edge.
    task automatic run_req(input logic [11:0] d, input logic z, input logic j,
                           input logic [2:0] s, output int lat,
                           output logic [15:0] dout, output logic o);
        @(negedge clk);
        in_valid = 1'b1; data_in = d; zext = z; jump = j; shamt = s;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        dout = data_out;
        o    = ovf;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_sext_noshift();
        int lat; logic [15:0] d; logic o;
        run_req(12'h001, 1'b0, 1'b0, 3'd0, lat, d, o);
        checks++; if (lat !== 1) begin failures++; $display("FAIL sext0_latency got=%0d exp=1", lat); end
        checks++; if (d !== 16'h0001) begin failures++; $display("FAIL sext0_data got=%h exp=0001", d); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL sext0_ovf got=%b exp=0", o); end
    endtask

    task automatic test_extension();
        int lat; logic [15:0] d; logic o;
        run_req(12'h800, 1'b0, 1'b0, 3'd0, lat, d, o);
        checks++; if (d !== 16'hF800) begin failures++; $display("FAIL sext_800_data got=%h exp=F800", d); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL sext_800_ovf got=%b exp=0", o); end
        run_req(12'h800, 1'b1, 1'b0, 3'd0, lat, d, o);
        checks++; if (d !== 16'h0800) begin failures++; $display("FAIL zext_800_data got=%h exp=0800", d); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL zext_800_ovf got=%b exp=0", o); end
    endtask

    task automatic test_jump();
        int lat; logic [15:0] d; logic o;
        run_req(12'h801, 1'b0, 1'b1, 3'd5, lat, d, o);
        checks++; if (lat !== 2) begin failures++; $display("FAIL jump_latency got=%0d exp=2", lat); end
        checks++; if (d !== 16'hF002) begin failures++; $display("FAIL jump_data got=%h exp=F002", d); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL jump_ovf got=%b exp=0", o); end
    endtask

    task automatic test_shift_ovf();
        int lat; logic [15:0] d; logic o;
        run_req(12'h7FF, 1'b0, 1'b0, 3'd3, lat, d, o);
        checks++; if (lat !== 4) begin failures++; $display("FAIL shift3_latency got=%0d exp=4", lat); end
        checks++; if (d !== 16'h3FF8) begin failures++; $display("FAIL shift3_data got=%h exp=3FF8", d); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL shift3_ovf got=%b exp=0", o); end
        run_req(12'h7FF, 1'b0, 1'b0, 3'd7, lat, d, o);
        checks++; if (lat !== 8) begin failures++; $display("FAIL shift7_latency got=%0d exp=8", lat); end
        checks++; if (d !== 16'hFF80) begin failures++; $display("FAIL shift7_data got=%h exp=FF80", d); end
        checks++; if (o !== 1'b1) begin failures++; $display("FAIL shift7_ovf got=%b exp=1", o); end
        run_req(12'h800, 1'b1, 1'b0, 3'd5, lat, d, o);
        checks++; if (lat !== 6) begin failures++; $display("FAIL zshift5_latency got=%0d exp=6", lat); end
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL zshift5_data got=%h exp=0000", d); end
        checks++; if (o !== 1'b1) begin failures++; $display("FAIL zshift5_ovf got=%b exp=1", o); end
    endtask

    task automatic test_backpressure();
        int lat;
        // 0x7FF << 7 sign-extended: FF80 with overflow.
        @(negedge clk);
        in_valid = 1'b1; data_in = 12'h7FF; zext = 1'b0; jump = 1'b0; shamt = 3'd7;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_reach_done got=%b exp=1", out_valid); end
        // Competing request offered during the stall must be ignored.
        @(negedge clk);
        in_valid = 1'b1; data_in = 12'h001; shamt = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_%0d got=%b exp=1", i, out_valid); end
            checks++; if (data_out !== 16'hFF80) begin failures++; $display("FAIL bp_data_%0d got=%h exp=FF80", i, data_out); end
            checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL bp_ovf_%0d got=%b exp=1", i, ovf); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_%0d got=%b exp=0", i, in_ready); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy_%0d got=%b exp=1", i, busy); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_stall_req_taken got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_shift();
        int lat; logic [15:0] d; logic o; int seen;
        @(negedge clk);
        in_valid = 1'b1; data_in = 12'h7FF; zext = 1'b0; jump = 1'b0; shamt = 3'd7;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL rst_mid_data got=%h exp=0000", data_out); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_no_result got=%0d exp=0", seen); end
        out_ready = 1'b0;
        run_req(12'h001, 1'b0, 1'b0, 3'd0, lat, d, o);
        checks++; if (d !== 16'h0001) begin failures++; $display("FAIL rst_mid_follow_data got=%h exp=0001", d); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL rst_mid_follow_latency got=%0d exp=1", lat); end
    endtask

    initial begin
        test_reset();
        test_sext_noshift();
        test_extension();
        test_jump();
        test_shift_ovf();
        test_backpressure();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
